// File: rtl/dmem_dump_ctrl_pkg.sv
// rtl/dmem_dump_ctrl_pkg.sv - shared state encoding and line-break helper for the dmem dump controller
package dmem_dump_ctrl_pkg;

    // Encodings are fixed so bench monitors can decode a probed state value.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

    function automatic logic closes_line(input logic [31:0] idx, input logic [31:0] per);
        return (per != 32'd0) && (((idx + 32'd1) % per) == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_dump_ctrl.sv
// rtl/dmem_dump_ctrl.sv - freezes the core at END_PC, drains the pipeline, then streams a dmem window out
module dmem_dump_ctrl
    import dmem_dump_ctrl_pkg::*;
#(
    parameter logic [31:0] END_PC       = 32'h78,
    parameter int          BASE_WORD    = 32,
    parameter int          NUM_WORDS    = 96,
    parameter int          WORDS_PER_LN = 16,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    output logic        halt,
    output logic [31:0] dump_addr,
    input  logic [31:0] dump_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic        dump_eol,
    output logic        dump_last,
    output logic        done
);

    localparam int IDX_W     = $clog2(NUM_WORDS + 1);
    // A zero drain request still spends one cycle in DRAIN so halt settles first.
    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int DRAIN_W   = (DRAIN_EFF > 1) ? $clog2(DRAIN_EFF) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_WORDS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_EFF - 1);

    dump_state_t        state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        drain_nxt  = drain_cnt;
        halt       = (state != ST_RUN);
        dump_valid = (state == ST_DUMP);
        done       = (state == ST_DONE);
        dump_last  = dump_valid && (idx == LAST_IDX);
        dump_eol   = dump_valid && closes_line(32'(idx), 32'(WORDS_PER_LN));
        dump_addr  = (32'(BASE_WORD) + 32'(idx)) << 2;
        dump_data  = dump_rdata;

        case (state)
            ST_RUN: begin
                if (pc_f == END_PC) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_DUMP;
                end else begin
                    drain_nxt = drain_cnt - DRAIN_W'(1);
                end
            end
            ST_DUMP: begin
                // dmem is frozen by halt, so holding idx keeps the word stable under backpressure.
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// tb/tb_dmem_dump_ctrl.sv - directed self-checking bench for dmem_dump_ctrl
module tb_dmem_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;

    logic        halt_a, valid_a, ready_a, eol_a, last_a, done_a;
    logic [31:0] addr_a, rdata_a, data_a;
    logic        halt_b, valid_b, ready_b, eol_b, last_b, done_b;
    logic [31:0] addr_b, rdata_b, data_b;

    logic [31:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_dump_ctrl dut_a (
        .clk(clk), .reset(reset), .pc_f(pc_f), .halt(halt_a),
        .dump_addr(addr_a), .dump_rdata(rdata_a), .dump_valid(valid_a),
        .dump_ready(ready_a), .dump_data(data_a), .dump_eol(eol_a),
        .dump_last(last_a), .done(done_a)
    );

    dmem_dump_ctrl #(.NUM_WORDS(1), .DRAIN_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .pc_f(pc_f), .halt(halt_b),
        .dump_addr(addr_b), .dump_rdata(rdata_b), .dump_valid(valid_b),
        .dump_ready(ready_b), .dump_data(data_b), .dump_eol(eol_b),
        .dump_last(last_b), .done(done_b)
    );

    assign rdata_a = mem[addr_a[9:2]];
    assign rdata_b = mem[addr_b[9:2]];

    function automatic logic [31:0] word_val(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_halt"}, 32'(halt_a), 32'd0);
        chk({tag, "_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_eol"}, 32'(eol_a), 32'd0);
        chk({tag, "_last"}, 32'(last_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
        chk({tag, "_addr"}, addr_a, 32'h80);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 0;
        while (!valid_a && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic dump_run(input string tag, input bit backpressure);
        int k   = 0;
        int cyc = 0;
        while (!done_a && cyc < 2000) begin
            ready_a = backpressure ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            chk({tag, "_valid"}, 32'(valid_a), 32'd1);
            chk({tag, "_addr"}, addr_a, 32'h80 + 32'(k) * 32'd4);
            chk({tag, "_data"}, data_a, word_val(32 + k));
            chk({tag, "_eol"}, 32'(eol_a), 32'(((k + 1) % 16) == 0));
            chk({tag, "_last"}, 32'(last_a), 32'(k == 95));
            if (valid_a && ready_a) k++;
            tick();
            cyc++;
        end
        chk({tag, "_count"}, 32'(k), 32'd96);
        chk({tag, "_done"}, 32'(done_a), 32'd1);
        chk({tag, "_done_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_done_halt"}, 32'(halt_a), 32'd1);
        chk({tag, "_done_last"}, 32'(last_a), 32'd0);
        ready_a = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word_val(i);
        reset   = 1'b1;
        pc_f    = 32'h78;
        ready_a = 1'b1;
        ready_b = 1'b1;

        // END_PC seen only while reset is held must not trigger
        tick(); tick(); tick();
        chk_idle("reset");
        chk("reset_b_halt", 32'(halt_b), 32'd0);
        chk("reset_b_done", 32'(done_b), 32'd0);
        reset = 1'b0;
        pc_f  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_halt", 32'(halt_a), 32'd0);
        end

        // normal program run up to END_PC
        for (int p = 0; p < 32'h78; p += 4) begin
            pc_f = 32'(p);
            tick();
            chk("run_halt", 32'(halt_a), 32'd0);
        end
        pc_f = 32'h78;
        tick();
        chk("hit_halt_a", 32'(halt_a), 32'd1);
        chk("hit_valid_a", 32'(valid_a), 32'd0);
        chk("hit_halt_b", 32'(halt_b), 32'd1);
        chk("hit_valid_b", 32'(valid_b), 32'd0);
        tick();
        chk("b_valid", 32'(valid_b), 32'd1);
        chk("b_last", 32'(last_b), 32'd1);
        chk("b_eol", 32'(eol_b), 32'd0);
        chk("b_addr", addr_b, 32'h80);
        chk("b_data", data_b, word_val(32));
        chk("a_valid_t1", 32'(valid_a), 32'd0);
        tick();
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_done_valid", 32'(valid_b), 32'd0);
        tick();
        chk("a_valid_t3", 32'(valid_a), 32'd0);
        tick();
        chk("a_valid_t4", 32'(valid_a), 32'd1);
        dump_run("full", 1'b0);

        // pc_f sweeping past END_PC again must not restart
        for (int p = 32'h70; p <= 32'h7c; p += 4) begin
            pc_f = 32'(p);
            tick();
            chk("again_done", 32'(done_a), 32'd1);
            chk("again_valid", 32'(valid_a), 32'd0);
            chk("again_halt", 32'(halt_a), 32'd1);
        end

        // reset in the middle of a dump, then a full restart
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_f  = 32'h0;
        tick();
        pc_f = 32'h78;
        tick();
        wait_valid("mid", 4);
        begin
            int n = 0;
            while (addr_a != 32'h120 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("mid_idx40_addr", addr_a, 32'h120);
        chk("mid_idx40_valid", 32'(valid_a), 32'd1);
        reset = 1'b1;
        tick();
        chk_idle("mid_reset");
        reset = 1'b0;
        pc_f  = 32'h0;
        tick();
        chk("mid_after_halt", 32'(halt_a), 32'd0);
        pc_f = 32'h78;
        tick();
        chk("restart_halt", 32'(halt_a), 32'd1);
        wait_valid("restart", 4);
        dump_run("restart", 1'b0);

        // backpressure: ready pattern 1,0,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_f  = 32'h78;
        tick();
        wait_valid("bp", 4);
        dump_run("bp", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
